// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 32-bit words into byte-wide little-endian memory and holds the CPU until a load completes
module instr_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  input  logic              in_valid_i,
  input  logic [31:0]       in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [2:0] {IDLE, WAIT, WR0, WR1, WR2, WR3, DONE} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic              err_q, err_d, hold_q, hold_d;
  logic              wr, top, last;
  assign wr  = state_q inside {WR0, WR1, WR2, WR3};
  assign top = &addr_q;
  assign last = (state_q == WR3) && (cnt_q == CNT_W'(1));
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    err_d   = err_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (start_i) begin
        err_d = 1'b0;
        if (word_count_i == '0) begin
          state_d = DONE;
          hold_d  = 1'b0;
        end else begin
          state_d = WAIT;
          addr_d  = base_addr_i;
          cnt_d   = word_count_i;
          hold_d  = 1'b1;
        end
      end
      WAIT: if (in_valid_i) begin
        word_d  = in_data_i;
        state_d = WR0;
      end
      WR0, WR1, WR2, WR3: begin
        cnt_d = (state_q == WR3) ? cnt_q - CNT_W'(1) : cnt_q;
        // the top byte ends the load; abort with err only if bytes remain
        if (last || top) begin
          state_d = DONE;
          hold_d  = 1'b0;
          err_d   = !last;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = state_q == WR0 ? WR1 : state_q == WR1 ? WR2 : state_q == WR2 ? WR3 : WAIT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end
  assign in_ready_o  = state_q == WAIT;
  assign mem_we_o    = wr;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = state_q == WR0 ? word_q[7:0]   :
                       state_q == WR1 ? word_q[15:8]  :
                       state_q == WR2 ? word_q[23:16] :
                       state_q == WR3 ? word_q[31:24] : 8'h00;
  assign busy_o      = state_q inside {WAIT, WR0, WR1, WR2, WR3};
  assign done_o      = state_q == DONE;
  assign err_o       = err_q;
  assign cpu_hold_o  = hold_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: random and directed loads checked every cycle against a byte-queue reference model
module tb_instr_mem_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [7:0]  word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;

  instr_mem_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
    .word_count_i(word_count), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .cpu_hold_o(cpu_hold), .busy_o(busy),
    .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  logic [7:0] dmem [1024];
  always @(posedge clk) if (mem_we) dmem[mem_addr] <= mem_wdata;

  // word source: holds the current word until the loader takes it
  logic [31:0] src_w [$];
  int src_rd = 0;
  int vprob = 100;
  logic hs = 1'b0;
  always @(negedge clk) hs = in_valid && in_ready;
  always @(posedge clk) begin
    if (hs) src_rd++;
    #1;
    in_valid = (src_rd < src_w.size()) && ($urandom_range(99) < vprob);
    in_data  = (src_rd < src_w.size()) ? src_w[src_rd] : $urandom;
  end

  // reference model: a load is a queue of pending bytes fed one word at a time
  logic       m_act = 1'b0, m_done = 1'b0, m_err = 1'b0, m_hold = 1'b1;
  logic [7:0] m_q [$];
  int         m_left = 0, m_addr = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_q.delete(); m_left = 0; m_addr = 0;
      m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_act) begin
      if (start) begin
        m_err = 1'b0;
        if (word_count == 0) begin
          m_done = 1'b1; m_hold = 1'b0;
        end else begin
          m_act = 1'b1; m_left = word_count; m_addr = base_addr; m_hold = 1'b1;
        end
      end
    end else if (m_q.size() == 0) begin
      if (in_valid) begin
        for (int k = 0; k < 4; k++) m_q.push_back(in_data[8*k +: 8]);
        m_left--;
      end
    end else begin
      void'(m_q.pop_front());
      if (m_q.size() == 0 && m_left == 0) begin
        m_act = 1'b0; m_done = 1'b1; m_hold = 1'b0;
      end else if (m_addr == 1023) begin
        m_act = 1'b0; m_done = 1'b1; m_hold = 1'b0; m_err = 1'b1; m_q.delete();
      end else begin
        m_addr++;
      end
    end
  end

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  // literal expectations posted by the stimulus process, checked by the compare process
  string       lit_nm [512];
  logic [31:0] lit_a [512], lit_e [512];
  int lit_n = 0, lit_rd = 0;
  task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
    lit_nm[lit_n] = nm; lit_a[lit_n] = a; lit_e[lit_n] = e;
    lit_n++;
  endtask

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_act && m_q.size() == 0);
    chk("mem_we", mem_we, m_q.size() > 0);
    chk("busy", busy, m_act);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("cpu_hold", cpu_hold, m_hold);
    if (m_q.size() > 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_q[0]);
    end
    while (lit_rd < lit_n) begin
      chk(lit_nm[lit_rd], lit_a[lit_rd], lit_e[lit_rd]);
      lit_rd++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [9:0] b, input int n, output int lat);
    int t0;
    logic seen;
    seen = 1'b0;
    start = 1'b1; base_addr = b; word_count = n[7:0]; t0 = cyc_n;
    tick();
    start = 1'b0; base_addr = 10'($urandom); word_count = 8'($urandom);
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) post("done_timeout", 0, 1);
    lat = cyc_n - t0;
    tick();
  endtask

  initial begin
    int lat, t0;
    repeat (3) @(posedge clk);
    #1;
    post("rst_we", mem_we, 0);
    post("rst_ready", in_ready, 0);
    post("rst_addr", mem_addr, 0);
    post("rst_wdata", mem_wdata, 0);
    post("rst_busy", busy, 0);
    post("rst_done", done, 0);
    post("rst_err", err, 0);
    post("rst_hold", cpu_hold, 1);
    rst_n = 1'b1;
    tick();

    src_w.push_back(32'h8C220004);
    load(10'h000, 1, lat);
    post("single_lat", lat, 6);
    post("single_b0", dmem[0], 8'h04);
    post("single_b1", dmem[1], 8'h00);
    post("single_b2", dmem[2], 8'h22);
    post("single_b3", dmem[3], 8'h8C);
    post("single_hold", cpu_hold, 0);

    vprob = 35;
    src_w.push_back(32'h11111111);
    src_w.push_back(32'h22222222);
    src_w.push_back(32'h33333333);
    load(10'h010, 3, lat);
    post("bp_10", dmem[10'h010], 8'h11);
    post("bp_13", dmem[10'h013], 8'h11);
    post("bp_14", dmem[10'h014], 8'h22);
    post("bp_18", dmem[10'h018], 8'h33);
    post("bp_1b", dmem[10'h01B], 8'h33);

    vprob = 100;
    load(10'h020, 0, lat);
    post("zero_lat", lat, 1);
    post("zero_err", err, 0);

    src_w.push_back(32'hA1B2C3D4);
    src_w.push_back(32'hDEADBEEF);
    load(10'h3FC, 2, lat);
    post("ovf_lat", lat, 6);
    post("ovf_err", err, 1);
    post("ovf_3fc", dmem[10'h3FC], 8'hD4);
    post("ovf_3ff", dmem[10'h3FF], 8'hA1);
    load(10'h000, 1, lat);
    post("ovf_clr_err", err, 0);
    post("ovf_next_b0", dmem[0], 8'hEF);
    post("ovf_next_lat", lat, 6);

    src_w.push_back(32'h04030201);
    src_w.push_back(32'h08070605);
    start = 1'b1; base_addr = 10'h040; word_count = 8'd2; t0 = cyc_n;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; base_addr = 10'h300; word_count = 8'd7;
    tick();
    start = 1'b0;
    repeat (6) tick();
    post("ign_done", done, 1);
    start = 1'b1; base_addr = 10'h300; word_count = 8'd7;
    tick();
    start = 1'b0;
    post("ign_busy", busy, 0);
    post("ign_ready", in_ready, 0);
    post("ign_40", dmem[10'h040], 8'h01);
    post("ign_47", dmem[10'h047], 8'h08);
    tick();

    src_w.push_back(32'hCAFEF00D);
    src_w.push_back(32'h12345678);
    start = 1'b1; base_addr = 10'h080; word_count = 8'd2;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    post("mid_rst_we", mem_we, 0);
    post("mid_rst_busy", busy, 0);
    post("mid_rst_ready", in_ready, 0);
    post("mid_rst_hold", cpu_hold, 1);
    post("mid_rst_81", dmem[10'h080], 8'h0D);
    tick();
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 30; r++) begin
      logic [9:0] b;
      int n;
      b = (r % 4 == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom);
      n = $urandom_range(0, 6);
      vprob = $urandom_range(30, 100);
      for (int i = 0; i < n; i++) src_w.push_back($urandom);
      load(b, n, lat);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the byte-wide, little-endian instruction/data memory that the pipelined MIPS CPU reads.
- Accepts 32-bit words over a valid/ready stream and writes each word as 4 consecutive bytes, LSB first, at an incrementing byte address.
- Holds the CPU in reset through `cpu_hold` until a load completes, so programs can be loaded in-system instead of from a preloaded file.

Parameters:
- ADDR_W, 10: byte-address width of the target memory (1024 bytes).
- CNT_W, 8: width of the word-count input (max 255 words per load).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first byte address of the load; captured on accepted start.
- word_count  in  CNT_W  number of 32-bit words to load; captured on accepted start.
- in_valid  in  1  source has a word on in_data.
- in_data  in  32  word to write.
- in_ready  out  1  loader can accept a word this cycle.
- mem_we  out  1  byte write strobe to memory.
- mem_addr  out  ADDR_W  byte address for the write.
- mem_wdata  out  8  byte to write.
- cpu_hold  out  1  1 = keep the CPU in reset.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse at the end of a load.
- err  out  1  sticky flag: the last load hit the end of the address space.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-load):
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
  - cpu_hold=1: the CPU stays held until the first completed load.
- All outputs are registered or decoded directly from state registers; there is no combinational path from any input to any output.
- State machine states: IDLE, WAIT, WR0, WR1, WR2, WR3, DONE.
- IDLE:
  - start=1 with word_count!=0 -> WAIT; capture base_addr and word_count; clear err; cpu_hold=1; busy=1.
  - start=1 with word_count=0 -> DONE; no writes are performed.
  - start is ignored in every other state.
- WAIT:
  - in_ready=1.
  - in_valid=1 -> latch in_data, go to WR0.
  - in_ready is 0 in all other states, so no word is ever dropped or double-accepted.
- WRk (k=0..3):
  - mem_we=1, mem_addr=current address, mem_wdata=word[8k+7:8k].
  - The address increments by 1 after each byte.
  - WR0 -> WR1 -> WR2 -> WR3.
  - From WR3: decrement the remaining-word count; if it reaches 0 go to DONE, else go to WAIT.
- Address boundary: if a byte is written at address 2^ADDR_W-1 and more bytes of the load remain:
  - set err=1 and go directly to DONE (abort).
  - The address never wraps to 0 and nothing is written past the top of memory.
  - If that byte is the final byte of the load, the load ends normally and err stays 0.
- DONE: done=1 for exactly one cycle, busy=0, cpu_hold=0 from this cycle on, then -> IDLE.
- cpu_hold stays 0 in IDLE until the next accepted start, which raises it in the same cycle that busy rises.
- Throughput:
  - Minimum 5 cycles per word: 1 handshake cycle plus 4 write cycles.
  - With in_valid held high, an N-word load takes 1+5N cycles from start to the done pulse.
- Simultaneous events:
  - start asserted in the same cycle as DONE is ignored.
  - in_valid asserted outside WAIT is ignored; the source must hold the word until in_ready.
- err stays set until the next accepted start or reset.

Test Plan:
- Reset mid-load: assert rst=0 during WR1 -> mem_we, busy, in_ready drop immediately; cpu_hold=1; state returns to IDLE.
- Single word: base_addr=0x000, word_count=1, in_data=0x8C220004 -> bytes 04,00,22,8C written to 0x000..0x003 on 4 consecutive cycles; done pulse; cpu_hold falls.
- Back-pressure: word_count=3 with in_valid toggling (2 idle cycles between words), data 0x11111111/0x22222222/0x33333333 from base 0x010 -> bytes land at 0x010..0x01B in order, no duplicates, in_ready high only in WAIT.
- Zero count: start with word_count=0 -> done one cycle later, mem_we never asserted, err=0.
- Address overflow: base_addr=0x3FC, word_count=2 -> 4 bytes written at 0x3FC..0x3FF, then err=1 and done with no second write; following start with base 0x000, count 1 clears err.
- Ignored start: pulse start during WR2 and during DONE -> no effect on addresses, counts, or states.
